// File: rtl/wire_pkg.sv
// Shared types and helpers for the gate-path exerciser.
`timescale 1ns/1ps
package wire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned NUM_VEC = 4;

  // Expected {NOT(A), A&B} for vector v = {A, B}.
  function automatic logic [1:0] exp_bits(input logic [1:0] v);
    return {~v[1], v[1] & v[0]};
  endfunction

endpackage

// File: rtl/wire_exerciser_sync2.sv
// Two-flop synchronizer for an asynchronous loop-back pin.
`timescale 1ns/1ps
module sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wire_exerciser.sv
// Sweeps A/B through all four vectors and checks the looped-back NOT/AND pins.
// WIRE_EXERCISER_LOOP_EN: free-running sweeps, DONE lasts one cycle, start ignored.
`timescale 1ns/1ps
module wire_exerciser
  import wire_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16000000,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               obs_not,
  input  logic               obs_and,
  output logic               drv_a,
  output logic               drv_b,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [NUM_VEC-1:0] err_vec
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t        state;
  logic [1:0]    v;
  logic [1:0]    v_next;
  logic [1:0]    expv;
  logic [SW-1:0] settle_cnt;
  logic [HW-1:0] hold_cnt;
  logic          sync_not;
  logic          sync_and;
  logic          go;

  sync2 u_sync_not (.CLK(CLK), .RST(RST), .d(obs_not), .q(sync_not));
  sync2 u_sync_and (.CLK(CLK), .RST(RST), .d(obs_and), .q(sync_and));

  assign v_next = v + 2'd1;
  assign expv   = exp_bits(v);

`ifdef WIRE_EXERCISER_LOOP_EN
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      v          <= 2'd0;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      drv_a      <= 1'b0;
      drv_b      <= 1'b0;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      err_vec    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state      <= DRIVE;
            v          <= 2'd0;
            settle_cnt <= '0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            fail       <= 1'b0;
`ifndef WIRE_EXERCISER_LOOP_EN
            err_vec    <= '0;
`endif
          end
        end
        DRIVE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE: begin
          err_vec[v] <= (sync_not != expv[1]) | (sync_and != expv[0]);
          hold_cnt   <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            if (v == 2'(NUM_VEC - 1)) begin
              // err_vec is complete here: the last SAMPLE preceded this HOLD.
              state <= DONE;
              busy  <= 1'b0;
              pass  <= (err_vec == '0);
              fail  <= (err_vec != '0);
            end else begin
              v          <= v_next;
              drv_a      <= v_next[1];
              drv_b      <= v_next[0];
              settle_cnt <= '0;
              state      <= DRIVE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wire_exerciser.sv
// Directed bench for wire_exerciser with a time-based sweep model and a per-cycle compare.
`timescale 1ns/1ps
module tb_wire_exerciser;

  localparam int HOLD   = 4;
  localparam int SETTLE = 3;
  localparam int VLEN   = SETTLE + 1 + HOLD;
  localparam int SWEEP  = 4 * VLEN;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       obs_not, obs_and;
  logic       drv_a, drv_b, busy, pass, fail;
  logic [3:0] err_vec;

  int mode = 0;  // 0 ideal gates, 1 obs_and stuck 0, 2 obs_not stuck 1
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  assign obs_not = (mode == 2) ? 1'b1 : ~drv_a;
  assign obs_and = (mode == 1) ? 1'b0 : (drv_a & drv_b);

  wire_exerciser #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RST(RST), .start(start), .obs_not(obs_not), .obs_and(obs_and),
    .drv_a(drv_a), .drv_b(drv_b), .busy(busy), .pass(pass), .fail(fail), .err_vec(err_vec)
  );

`ifdef WIRE_EXERCISER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // Model: position in sweep m_t (0..SWEEP-1) after busy rises; vector k is judged
  // once SETTLE+1 cycles of its slot have elapsed.
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         m_t      = 0;
  logic [3:0] m_err    = 4'h0;

  function automatic logic mism(input int md, input int k);
    logic a, b, on, oa;
    a  = k[1];
    b  = k[0];
    on = (md == 2) ? 1'b1 : ~a;
    oa = (md == 1) ? 1'b0 : (a & b);
    return (on != ~a) || (oa != (a & b));
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
      m_err    <= 4'h0;
    end else if (m_active) begin
      if (m_t == SWEEP - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_t <= m_t + 1;
        if ((m_t + 1) % VLEN == SETTLE + 1)
          m_err[(m_t + 1) / VLEN] <= mism(mode, (m_t + 1) / VLEN);
      end
    end else if (LOOP || start) begin
      m_active <= 1'b1;
      m_done   <= 1'b0;
      m_t      <= 0;
      if (!LOOP) m_err <= 4'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_active));
      check("drv", 32'({drv_a, drv_b}),
            m_active ? 32'(m_t / VLEN) : (m_done ? 32'd3 : 32'd0));
      check("err_vec", 32'(err_vec), 32'(m_err));
      check("pass", 32'(pass), 32'(m_done && m_err == 4'h0));
      check("fail", 32'(fail), 32'(m_done && m_err != 4'h0));
    end
  end

  // Length of the most recent busy run, for the sweep-length checks.
  int run_len = 0;
  int last_len = 0;
  always @(negedge CLK) begin
    run_len <= busy ? run_len + 1 : 0;
    if (!busy && run_len != 0) last_len <= run_len;
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for busy, then for the verdict; returns on the first DONE negedge.
  task automatic run_sweep(input string name);
    bit seen_busy = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 4 * SWEEP && !done; i++) begin
      @(negedge CLK);
      if (busy) seen_busy = 1'b1;
      else if (seen_busy && (pass || fail)) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for verdict, got busy=%0b want done", name, busy);
    end
    #1;
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int cyc;
    #1 RST = 1'b1;
    @(negedge CLK);
    chk_en = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drv", 32'({drv_a, drv_b}), 32'd0);
    check("rst_flags", 32'({pass, fail, err_vec}), 32'd0);
    tick();
    RST = 1'b0;

`ifndef WIRE_EXERCISER_LOOP_EN
    // Ideal sweep, with a stray start mid-sweep.
    mode = 0;
    pulse_start();
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sweep("ideal");
    check("ideal_pass", 32'(pass), 32'd1);
    check("ideal_fail", 32'(fail), 32'd0);
    check("ideal_err", 32'(err_vec), 32'h0);
    check("ideal_drv", 32'({drv_a, drv_b}), 32'd3);
    check("ideal_len", 32'(last_len), 32'd32);

    mode = 1;
    pulse_start();
    run_sweep("and_stuck0");
    check("and0_err", 32'(err_vec), 32'h8);
    check("and0_pf", 32'({pass, fail}), 32'b01);

    // Restart from DONE: flags clear the cycle after start.
    mode = 2;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge CLK);
    check("restart_clear", 32'({busy, pass, fail, err_vec}), 32'b100_0000);
    run_sweep("not_stuck1");
    check("not1_err", 32'(err_vec), 32'hC);
    check("not1_fail", 32'(fail), 32'd1);

    // Reset during HOLD of vector 2.
    pulse_start();
    repeat (21) tick();
    check("pre_rst_err", 32'(err_vec), 32'h4);
    RST = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_drv", 32'({drv_a, drv_b}), 32'd0);
    check("abort_err", 32'(err_vec), 32'h0);
    tick();
    RST = 1'b0;
    mode = 0;
    pulse_start();
    run_sweep("post_rst");
    check("post_rst_pass", 32'(pass), 32'd1);
    check("post_rst_len", 32'(last_len), 32'd32);

    // start held high in DONE restarts the sweep.
    tick();
    start = 1'b1;
    run_sweep("held_a");
    @(negedge CLK);
    check("held_restart", 32'({busy, pass}), 32'b10);
    tick();
    start = 1'b0;
    run_sweep("held_b");
    check("held_pass", 32'(pass), 32'd1);
`else
    mode = 0;
    pulses = 0;
    last_pulse = -1;
    cyc = 0;
    repeat (4 * (SWEEP + 1) + 4) begin
      @(negedge CLK);
      cyc++;
      if (pass) begin
        if (last_pulse >= 0) check("loop_period", 32'(cyc - last_pulse), 32'd33);
        last_pulse = cyc;
        pulses++;
      end
    end
    check("loop_pulses", 32'(pulses), 32'd4);
    check("loop_err", 32'(err_vec), 32'h0);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
